// File: rtl/hack_mem_pkg.sv
// Shared Hack data-memory constants and the screen scanner fetch-state type.
package hack_mem_pkg;

    localparam int              ADDR_W       = 15;
    localparam int              WORD_W       = 16;
    localparam int              BIT_W        = $clog2(WORD_W);
    localparam int              SCREEN_WORDS = 8192;
    localparam logic [ADDR_W-1:0] SCREEN_BASE = 15'h4000;
    localparam logic [ADDR_W-1:0] KBD_ADDR    = 15'h6000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } fetch_state_e;

endpackage

// File: rtl/hack_pixel_shifter.sv
// One-word pixel shifter: loads a 16-bit word and emits it LSB-first
// over a valid/ready handshake, reloading on its last bit with no bubble.
module hack_pixel_shifter
    import hack_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_avail,
    input  logic [WORD_W-1:0] load_data,
    output logic              load,
    input  logic              pix_ready,
    output logic              pix_valid,
    output logic              pix_data,
    output logic              xfer
);

    logic [WORD_W-1:0] shift_reg;
    logic [BIT_W-1:0]  bit_cnt;
    logic              empty;
    logic              last_bit;

    assign pix_valid = !empty;
    assign pix_data  = shift_reg[0];
    assign xfer      = pix_valid && pix_ready;
    assign last_bit  = xfer && (bit_cnt == BIT_W'(WORD_W - 1));
    assign load      = load_avail && (empty || last_bit);

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            empty     <= 1'b1;
        end else if (load) begin
            shift_reg <= load_data;
            bit_cnt   <= '0;
            empty     <= 1'b0;
        end else if (xfer) begin
            // Zero-fill keeps pix_data low once the word has drained.
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + 1'b1;
            if (last_bit) begin
                empty <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/hack_screen_scanner.sv
// Reads the Hack screen frame buffer over a shared req/gnt port and streams
// it out as 1-bit pixels with scanline and frame markers.
module hack_screen_scanner
    import hack_mem_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR     = SCREEN_BASE,
    parameter int                WORDS_PER_ROW = 32,
    parameter int                ROWS          = SCREEN_WORDS / WORDS_PER_ROW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_data,
    output logic              pix_sol,
    output logic              pix_eol,
    output logic              pix_sof,
    output logic              frame_done
);

    localparam int TOTAL_WORDS = WORDS_PER_ROW * ROWS;
    localparam int PIX_PER_ROW = WORDS_PER_ROW * WORD_W;
    localparam int IDX_W       = $clog2(TOTAL_WORDS + 1);
    localparam int COL_W       = $clog2(PIX_PER_ROW);
    localparam int ROW_W       = (ROWS > 1) ? $clog2(ROWS) : 1;

    fetch_state_e      state;
    logic [IDX_W-1:0]  fetch_idx;
    logic              buf_full;
    logic [WORD_W-1:0] buf_data;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              grant;
    logic              load;
    logic              xfer;
    logic              last_col;
    logic              last_row;
    logic              last_pix;

    assign mem_req  = (state == REQ) && !buf_full && (fetch_idx < IDX_W'(TOTAL_WORDS));
    assign mem_addr = BASE_ADDR + ADDR_W'(fetch_idx);
    assign grant    = mem_req && mem_gnt;

    assign last_col = (col == COL_W'(PIX_PER_ROW - 1));
    assign last_row = (row == ROW_W'(ROWS - 1));
    assign last_pix = xfer && last_col && last_row;

    assign pix_sol  = pix_valid && (col == '0);
    assign pix_eol  = pix_valid && last_col;
    assign pix_sof  = pix_valid && (col == '0) && (row == '0);

    // A grant into an empty buffer bypasses straight to an idle shifter.
    hack_pixel_shifter u_shifter (
        .clk        (clk),
        .reset      (reset),
        .load_avail (buf_full || grant),
        .load_data  (buf_full ? buf_data : mem_rdata),
        .load       (load),
        .pix_ready  (pix_ready),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .xfer       (xfer)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fetch_idx  <= '0;
            buf_full   <= 1'b0;
            buf_data   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= last_pix;

            case (state)
                IDLE:    if (enable) state <= REQ;
                REQ:     if (grant && fetch_idx == IDX_W'(TOTAL_WORDS - 1)) state <= DRAIN;
                DRAIN:   if (last_pix) state <= enable ? REQ : IDLE;
                default: state <= IDLE;
            endcase

            if (state == DRAIN && last_pix) begin
                fetch_idx <= '0;
            end else if (grant) begin
                fetch_idx <= fetch_idx + 1'b1;
            end

            // mem_req implies an empty buffer, so a grant can never clobber held data.
            if (load) begin
                buf_full <= 1'b0;
            end else if (grant) begin
                buf_full <= 1'b1;
                buf_data <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (xfer) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hack_screen_scanner.sv
// Directed bench for hack_screen_scanner: a memory/arbiter responder plus a
// pixel scoreboard driven once per cycle, with hand-computed expectations.
module tb_hack_screen_scanner;

    // Eight scanlines per frame keeps each frame at 4096 pixels.
    localparam int TB_ROWS     = 8;
    localparam int FRAME_WORDS = 32 * TB_ROWS;
    localparam int FRAME_PIX   = FRAME_WORDS * 16;
    localparam int BASE        = 'h4000;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        mem_req;
    logic [14:0] mem_addr;
    logic        mem_gnt;
    logic [15:0] mem_rdata;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_data;
    logic        pix_sol;
    logic        pix_eol;
    logic        pix_sof;
    logic        frame_done;

    hack_screen_scanner #(.ROWS(TB_ROWS)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rdata  (mem_rdata),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_sol    (pix_sol),
        .pix_eol    (pix_eol),
        .pix_sof    (pix_sof),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [0:FRAME_WORDS-1];

    int tests = 0;
    int fails = 0;

    // Responder / scoreboard state
    int          cyc = 0;
    int          ready_mode = 0;
    int          rcnt;
    bit          spurious = 1'b0;
    int          stall_left;
    int          exp_idx;
    int          exp_fetch;
    logic        exp_done;
    logic        prev_stall;
    logic        prev_data;
    int          pix_err, addr_err, done_err, stable_err;
    int          done_cnt, eol_cnt, sof_cnt, req_cnt, valid_cnt;
    logic [31:0] cap;
    int          cap_n;
    int          first_gnt_cyc, first_valid_cyc, first_xfer_cyc, last_xfer_cyc;
    logic [2:0]  first_flags;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        rcnt = 0; stall_left = 0; exp_idx = 0; exp_fetch = 0; exp_done = 1'b0;
        prev_stall = 1'b0; prev_data = 1'b0;
        pix_err = 0; addr_err = 0; done_err = 0; stable_err = 0;
        done_cnt = 0; eol_cnt = 0; sof_cnt = 0; req_cnt = 0; valid_cnt = 0;
        cap = '0; cap_n = 0; first_flags = '0;
        first_gnt_cyc = -1; first_valid_cyc = -1; first_xfer_cyc = -1; last_xfer_cyc = -1;
    endtask

    // One clock: sample just after the edge, score the pixel port, then
    // drive ready and the arbiter response for the cycle that follows.
    task automatic cycle();
        logic [15:0] w;
        int          off;
        @(posedge clk);
        #1;
        cyc++;
        if (frame_done !== exp_done) done_err++;
        if (frame_done === 1'b1) done_cnt++;
        exp_done = 1'b0;
        if (mem_req === 1'b1) req_cnt++;
        if (pix_valid === 1'b1) valid_cnt++;
        if (pix_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (prev_stall && (pix_valid !== 1'b1 || pix_data !== prev_data)) stable_err++;

        pix_ready  = (ready_mode == 0) || (rcnt % 4 == 0) || (rcnt % 4 == 3);
        rcnt++;
        prev_stall = (pix_valid === 1'b1) && !pix_ready;
        prev_data  = pix_data;

        if (pix_valid === 1'b1 && pix_ready) begin
            w = mem[8'(exp_idx / 16)];
            if (pix_data !== w[4'(exp_idx % 16)] ||
                pix_sof  !== (exp_idx == 0) ||
                pix_sol  !== (exp_idx % 512 == 0) ||
                pix_eol  !== (exp_idx % 512 == 511)) pix_err++;
            if (pix_eol === 1'b1) eol_cnt++;
            if (pix_sof === 1'b1) sof_cnt++;
            if (cap_n < 32) begin
                cap[5'(cap_n)] = pix_data;
                if (cap_n == 0) begin
                    first_xfer_cyc = cyc;
                    first_flags    = {pix_sof, pix_sol, pix_eol};
                end
                if (cap_n == 31) last_xfer_cyc = cyc;
            end
            cap_n++;
            exp_done = (exp_idx == FRAME_PIX - 1);
            exp_idx  = (exp_idx + 1) % FRAME_PIX;
        end

        if (stall_left > 0) begin
            stall_left--;
            mem_gnt   = 1'b0;
            mem_rdata = 16'h0000;
        end else if (mem_req === 1'b1) begin
            off = int'(mem_addr) - BASE;
            if (off != exp_fetch) addr_err++;
            mem_gnt   = 1'b1;
            mem_rdata = (off >= 0 && off < FRAME_WORDS) ? mem[8'(off)] : 16'hDEAD;
            exp_fetch = (exp_fetch + 1) % FRAME_WORDS;
            if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
        end else if (spurious) begin
            mem_gnt   = 1'b1;
            mem_rdata = 16'hFFFF;
        end else begin
            mem_gnt   = 1'b0;
            mem_rdata = 16'($urandom);
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        clear_model();
        repeat (2) cycle();
        reset = 1'b0;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < FRAME_WORDS; i++) mem[i] = 16'(i * 40503 + 4660);
    endtask

    initial begin
        int   n;
        bit   stalled;
        logic [14:0] stall_addr;
        int   sa_err;

        reset = 1'b1; enable = 1'b1; mem_gnt = 1'b0; mem_rdata = '0; pix_ready = 1'b0;
        fill_mem();
        mem[0] = 16'h0001;
        mem[1] = 16'h8000;
        clear_model();

        // Reset held three cycles with enable high, then release.
        repeat (3) begin
            cycle();
            check("rst_outs", 32'({mem_req, pix_valid, pix_data, pix_sol, pix_eol, pix_sof, frame_done}), 32'h0);
            check("rst_addr", 32'(mem_addr), 32'h4000);
        end
        reset = 1'b0;
        cycle();
        check("req_latency", 32'(mem_req), 32'h1);
        check("first_addr", 32'(mem_addr), 32'h4000);

        // Word order with immediate grants and ready held high.
        n = 0;
        while (cap_n < 32 && n < 200) begin cycle(); n++; end
        check("word_order", cap, 32'h8000_0001);
        check("first_flags", 32'(first_flags), 32'h6);
        check("valid_latency", first_valid_cyc - first_gnt_cyc, 32'd1);
        check("no_gaps", last_xfer_cyc - first_xfer_cyc, 32'd31);
        check("order_pix_err", pix_err, 32'd0);
        check("order_addr_err", addr_err, 32'd0);

        // Back-pressure with ready pattern 1,0,0,1.
        mem[0] = 16'hA5A5;
        ready_mode = 1;
        reset_dut();
        n = 0;
        while (cap_n < 16 && n < 200) begin cycle(); n++; end
        check("bp_sequence", 32'(cap[15:0]), 32'h0000_A5A5);
        check("bp_stable", stable_err, 32'd0);
        check("bp_pix_err", pix_err, 32'd0);

        // Two full frames, spurious grants while idle, one 40-cycle grant stall.
        fill_mem();
        ready_mode = 0;
        spurious   = 1'b1;
        reset_dut();
        stalled = 1'b0;
        sa_err  = 0;
        n = 0;
        while (done_cnt < 2 && n < 12000) begin
            cycle();
            n++;
            if (frame_done === 1'b1) begin
                check("wrap_req", 32'(mem_req), 32'h1);
                check("wrap_addr", 32'(mem_addr), 32'h4000);
            end
            if (!stalled && exp_idx == 100) begin
                stalled    = 1'b1;
                stall_left = 40;
                cycle();
                stall_addr = mem_addr;
                repeat (39) begin
                    cycle();
                    if (mem_addr !== stall_addr) sa_err++;
                end
                check("stall_valid_drop", 32'(pix_valid), 32'h0);
                check("stall_req_held", 32'(mem_req), 32'h1);
                check("stall_addr", sa_err, 32'd0);
            end
        end
        check("frame_budget", 32'(n < 12000), 32'h1);
        check("frame_pix_err", pix_err, 32'd0);
        check("frame_addr_err", addr_err, 32'd0);
        check("frame_done_timing", done_err, 32'd0);
        check("frame_eol_count", eol_cnt, 32'd16);
        check("frame_sof_count", sof_cnt, 32'd2);

        // Reset asserted at pixel 1000 aborts the frame.
        spurious = 1'b0;
        reset_dut();
        n = 0;
        while (exp_idx < 1000 && n < 3000) begin cycle(); n++; end
        reset = 1'b1;
        cycle();
        check("abort_outs", 32'({mem_req, pix_valid, pix_data, pix_sol, pix_eol, pix_sof, frame_done}), 32'h0);
        check("abort_addr", 32'(mem_addr), 32'h4000);
        clear_model();
        enable = 1'b0;
        cycle();
        reset = 1'b0;
        repeat (20) cycle();
        check("abort_no_done", done_cnt, 32'd0);
        check("abort_idle_req", req_cnt, 32'd0);

        // Enable dropped at pixel 1000: the frame completes, then idle.
        enable = 1'b1;
        reset_dut();
        n = 0;
        while (exp_idx < 1000 && n < 3000) begin cycle(); n++; end
        enable = 1'b0;
        n = 0;
        while (done_cnt < 1 && n < 8000) begin cycle(); n++; end
        check("stop_done_seen", done_cnt, 32'd1);
        check("stop_req_at_done", 32'(mem_req), 32'h0);
        req_cnt   = 0;
        valid_cnt = 0;
        repeat (20) cycle();
        check("stop_idle_req", req_cnt, 32'd0);
        check("stop_idle_valid", valid_cnt, 32'd0);
        check("stop_single_done", done_cnt, 32'd1);
        check("stop_addr", 32'(mem_addr), 32'h4000);
        check("stop_pix_err", pix_err, 32'd0);
        check("stop_eol_count", eol_cnt, 32'd8);
        check("stop_done_timing", done_err, 32'd0);
        check("stop_addr_err", addr_err, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
